// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on request and result sides.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [1:0]      dbg_state
);
  // Handshake: a request is taken on a rising edge where in_valid && in_ready;
  // a result is consumed on a rising edge where out_valid && out_ready. out_valid
  // and out_result stay stable until consumed or flushed.

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t            state;
  logic [2:0]        op_r;
  logic              neg_res;
  logic              neg_a_r;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [CW-1:0]     cnt;

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  // Operand decode on the request side.
  logic            a_sgn, b_sgn, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  assign a_sgn    = (in_op == 3'b001) || (in_op == 3'b010) || (in_op == 3'b100) || (in_op == 3'b110);
  assign b_sgn    = (in_op == 3'b001) || (in_op == 3'b100) || (in_op == 3'b110);
  assign neg_a    = a_sgn && in_a[XLEN-1];
  assign neg_b    = b_sgn && in_b[XLEN-1];
  assign abs_a    = neg_a ? -in_a : in_a;
  assign abs_b    = neg_b ? -in_b : in_b;
  assign div_zero = in_op[2] && (in_b == '0);
  assign div_ovf  = in_op[2] && !in_op[0] && (in_a == INT_MIN) && (&in_b);
  assign special_res = div_zero ? (in_op[1] ? in_a : '1)
                                : (in_op[1] ? '0   : in_a);

  // One iteration of each datapath.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? mag_a : '0)};
  assign div_shift = {rem, quo[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, mag_b};
  assign div_diff  = div_shift[XLEN-1:0] - mag_b;

  // Sign fix-up and result select.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  assign prod_s = neg_res ? -prod : prod;
  assign quo_s  = neg_res ? -quo : quo;
  assign rem_s  = neg_a_r ? -rem : rem;

  always_comb begin
    fix_res = '0;
    if (!op_r[2]) fix_res = (op_r[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else          fix_res = op_r[1] ? rem_s : quo_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_r       <= '0;
      neg_res    <= 1'b0;
      neg_a_r    <= 1'b0;
      mag_a      <= '0;
      mag_b      <= '0;
      prod       <= '0;
      quo        <= '0;
      rem        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r    <= in_op;
          neg_res <= neg_a ^ neg_b;
          neg_a_r <= neg_a;
          mag_a   <= abs_a;
          mag_b   <= abs_b;
          prod    <= {{XLEN{1'b0}}, abs_b};
          quo     <= abs_a;
          rem     <= '0;
          cnt     <= '0;
          if (div_zero || div_ovf) begin
            out_result <= special_res;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          if (!op_r[2]) begin
            prod <= {mul_sum, prod[XLEN-1:1]};
          end else begin
            rem <= div_ge ? div_diff : div_shift[XLEN-1:0];
            quo <= {quo[XLEN-2:0], div_ge};
          end
          if (cnt == CW'(XLEN-1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          out_result <= fix_res;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
